// File: rtl/cdc_2phase_clearable_link_if.sv
// Port bundle for the clearable two-phase link: the source and destination valid/ready
// channels plus the clear request and clear-pending signals of each side.
interface cdc_2phase_clearable_link_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  src_clear_i;
    logic                  src_clear_pending_o;
    logic [DATA_WIDTH-1:0] src_data_i;
    logic                  src_valid_i;
    logic                  src_ready_o;
    logic                  dst_clear_i;
    logic                  dst_clear_pending_o;
    logic [DATA_WIDTH-1:0] dst_data_o;
    logic                  dst_valid_o;
    logic                  dst_ready_i;

    // Driving side (source producer, destination consumer, clear requesters).
    modport master (
        output src_clear_i,
        input  src_clear_pending_o,
        output src_data_i,
        output src_valid_i,
        input  src_ready_o,
        output dst_clear_i,
        input  dst_clear_pending_o,
        input  dst_data_o,
        input  dst_valid_o,
        output dst_ready_i
    );

    // The link itself.
    modport slave (
        input  src_clear_i,
        output src_clear_pending_o,
        input  src_data_i,
        input  src_valid_i,
        output src_ready_o,
        input  dst_clear_i,
        output dst_clear_pending_o,
        output dst_data_o,
        output dst_valid_o,
        input  dst_ready_i
    );
endinterface

// File: rtl/cdc_2phase_clearable_link.sv
// Single-clock model of a clearable toggle req/ack handshake crossing. Req and ack travel
// through SYNC_STAGES-deep flop chains so latency matches the real two-clock crossing.
module cdc_2phase_clearable_link #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    cdc_2phase_clearable_link_if.slave  link
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam int              CNT_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_STAGES);

    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       clr_cnt_q, clr_cnt_d;
    logic                   req_q, req_d;
    logic                   ack_q, ack_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;

    logic pending;
    logic clear_req;
    logic clear_start;
    logic zero_state;
    logic blk;
    logic src_ready;
    logic dst_valid;
    logic src_fire;
    logic dst_fire;

    assign pending     = (state_q == ST_CLEAR);
    assign clear_req   = link.src_clear_i | link.dst_clear_i;
    assign clear_start = ~pending & clear_req;
    // Handshake state is forced to zero on the entry edge and for the whole sequence.
    assign zero_state  = clear_start | pending;
    assign blk         = pending | clear_req;

    assign src_ready = (req_q == ack_sync_q[SYNC_STAGES-1]) & ~blk;
    assign dst_valid = (req_sync_q[SYNC_STAGES-1] != ack_q) & ~blk;
    assign src_fire  = link.src_valid_i & src_ready;
    assign dst_fire  = dst_valid & link.dst_ready_i;

    assign link.src_ready_o         = src_ready;
    assign link.dst_valid_o         = dst_valid;
    assign link.dst_data_o          = data_q;
    assign link.src_clear_pending_o = pending;
    assign link.dst_clear_pending_o = pending;

    // Clear sequencer: SYNC_STAGES+1 cycles in CLEAR, new requests ignored meanwhile.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Source toggle, holding register and destination toggle.
    always_comb begin
        req_d  = req_q;
        ack_d  = ack_q;
        data_d = data_q;
        if (zero_state) begin
            req_d  = 1'b0;
            ack_d  = 1'b0;
            data_d = '0;
        end else begin
            if (src_fire) begin
                req_d  = ~req_q;
                data_d = link.src_data_i;
            end
            if (dst_fire) begin
                ack_d = ~ack_q;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_head
                assign req_sync_d[gi] = zero_state ? 1'b0 : req_q;
                assign ack_sync_d[gi] = zero_state ? 1'b0 : ack_q;
            end else begin : g_tail
                assign req_sync_d[gi] = zero_state ? 1'b0 : req_sync_q[gi-1];
                assign ack_sync_d[gi] = zero_state ? 1'b0 : ack_sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            req_q      <= 1'b0;
            ack_q      <= 1'b0;
            data_q     <= '0;
            req_sync_q <= '0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            req_q      <= req_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            req_sync_q <= req_sync_d;
            ack_sync_q <= ack_sync_d;
        end
    end
endmodule

// File: tb/tb_cdc_2phase_clearable_link.sv
// Bench for the clearable two-phase link: directed scenarios plus a random regression,
// all checked every cycle against a timestamp-based model of the channel.
module tb_cdc_2phase_clearable_link;
    localparam int DW = 32;
    localparam int S  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdc_2phase_clearable_link_if #(.DATA_WIDTH(DW)) link();

    cdc_2phase_clearable_link #(.DATA_WIDTH(DW), .SYNC_STAGES(S)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .link  (link)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit started = 1'b0;

    // Model: at most one word in the channel, described by when it becomes visible
    // and when the source may send again.
    bit            m_has = 1'b0;
    bit            m_clr = 1'b0;
    logic [DW-1:0] m_data = '0;
    int            m_vis_at = 0;
    int            m_ready_at = 0;
    int            m_clr_end = 0;
    int            n_sent = 0;
    int            n_drop = 0;
    int            n_rx = 0;

    bit            seq_mode = 1'b0;
    int            last_seq = -1;
    logic [DW-1:0] rx_q[$];
    int            rise_q[$];
    bit            prev_valid = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit exp_blk();
        return m_clr | link.src_clear_i | link.dst_clear_i;
    endfunction

    function automatic bit exp_ready();
        return !m_has && (cyc >= m_ready_at) && !exp_blk();
    endfunction

    function automatic bit exp_valid();
        return m_has && (cyc >= m_vis_at) && !exp_blk();
    endfunction

    always @(posedge clk) begin : model_upd
        bit rdy;
        bit vld;
        int nc;
        rdy = exp_ready();
        vld = exp_valid();
        nc  = cyc + 1;
        if (rst) begin
            if (m_has) n_drop++;
            m_has = 1'b0; m_clr = 1'b0; m_data = '0;
            m_ready_at = 0; m_vis_at = 0;
            started = 1'b1;
        end else if (m_clr) begin
            if (nc == m_clr_end) m_clr = 1'b0;
        end else if (link.src_clear_i || link.dst_clear_i) begin
            if (m_has) n_drop++;
            m_has = 1'b0; m_clr = 1'b1; m_data = '0;
            m_clr_end  = nc + S + 1;
            m_ready_at = m_clr_end;
        end else if (rdy && link.src_valid_i) begin
            m_has = 1'b1; m_data = link.src_data_i;
            m_vis_at = nc + S;
            n_sent++;
        end else if (vld && link.dst_ready_i) begin
            m_has = 1'b0;
            m_ready_at = nc + S;
        end
        cyc = nc;
    end

    always @(negedge clk) begin
        if (started) begin
            check("src_ready", {31'd0, link.src_ready_o}, {31'd0, exp_ready()});
            check("dst_valid", {31'd0, link.dst_valid_o}, {31'd0, exp_valid()});
            check("dst_data", link.dst_data_o, m_data);
            check("src_pending", {31'd0, link.src_clear_pending_o}, {31'd0, m_clr});
            check("dst_pending", {31'd0, link.dst_clear_pending_o}, {31'd0, m_clr});
            if (link.dst_valid_o && !prev_valid) rise_q.push_back(cyc);
            prev_valid = link.dst_valid_o;
            if (link.dst_valid_o && link.dst_ready_i && !rst) begin
                rx_q.push_back(link.dst_data_o);
                n_rx++;
                if (seq_mode) begin
                    check("rx_order", {31'd0, (int'(link.dst_data_o[15:0]) > last_seq)}, 32'd1);
                    last_seq = int'(link.dst_data_o[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!link.src_ready_o && n < 60) begin tick(); n++; end
        check("wait_ready", {31'd0, link.src_ready_o}, 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!link.dst_valid_o && n < 60) begin tick(); n++; end
        check("wait_valid", {31'd0, link.dst_valid_o}, 32'd1);
    endtask

    // Offer a word, return the edge index at which it was accepted.
    task automatic send(input logic [DW-1:0] w, output int acc);
        link.src_data_i  = w;
        link.src_valid_i = 1'b1;
        #0;
        wait_ready();
        tick();
        acc = cyc;
        link.src_valid_i = 1'b0;
    endtask

    task automatic count_pending(output int n);
        n = 0;
        while (link.src_clear_pending_o && n < 30) begin n++; tick(); end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_src_ready"}, {31'd0, link.src_ready_o}, 32'd1);
        check({tag, "_dst_valid"}, {31'd0, link.dst_valid_o}, 32'd0);
        check({tag, "_dst_data"}, link.dst_data_o, 32'd0);
        check({tag, "_src_pend"}, {31'd0, link.src_clear_pending_o}, 32'd0);
        check({tag, "_dst_pend"}, {31'd0, link.dst_clear_pending_o}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] words[3];
        int acc[3];
        int a;
        int m;
        int n;
        int seq;
        bit holding;
        bit fire;

        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;

        link.src_clear_i = 1'b0; link.dst_clear_i = 1'b0;
        link.src_valid_i = 1'b0; link.src_data_i = '0; link.dst_ready_i = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Stream three words with the destination always ready.
        rx_q.delete(); rise_q.delete();
        link.dst_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) send(words[i], acc[i]);
        repeat (8) tick();
        check("stream_count", rx_q.size(), 32'd3);
        check("stream_rises", rise_q.size(), 32'd3);
        if (rx_q.size() == 3 && rise_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("stream_word", rx_q[i], words[i]);
                check("stream_latency", rise_q[i] - acc[i], 32'd3);
                if (i > 0) check("stream_gap", acc[i] - acc[i-1], 32'd8);
            end
        end

        // Destination backpressure.
        link.dst_ready_i = 1'b0;
        send(32'hA5A5A5A5, a);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_valid", {31'd0, link.dst_valid_o}, 32'd1);
            check("bp_data", link.dst_data_o, 32'hA5A5A5A5);
            check("bp_src_ready", {31'd0, link.src_ready_o}, 32'd0);
        end
        link.dst_ready_i = 1'b1;
        tick();
        m = cyc;
        link.dst_ready_i = 1'b0;
        n = 0;
        while (!link.src_ready_o && n < 20) begin tick(); n++; end
        check("bp_ready_latency", cyc - m, 32'd3);

        // Source clear with a word in flight.
        rx_q.delete();
        send(32'hDEADBEEF, a);
        tick();
        link.src_clear_i = 1'b1;
        #1;
        check("sclr_ready_low", {31'd0, link.src_ready_o}, 32'd0);
        check("sclr_valid_low", {31'd0, link.dst_valid_o}, 32'd0);
        tick();
        link.src_clear_i = 1'b0;
        count_pending(n);
        check("sclr_pending_len", n, 32'd4);
        link.dst_ready_i = 1'b1;
        repeat (6) tick();
        check("sclr_dropped", rx_q.size(), 32'd0);
        send(32'h12345678, a);
        repeat (6) tick();
        check("sclr_next_count", rx_q.size(), 32'd1);
        if (rx_q.size() == 1) check("sclr_next_word", rx_q[0], 32'h12345678);

        // Destination clear while a word is offered.
        link.dst_ready_i = 1'b0;
        send(32'hCAFEF00D, a);
        wait_valid();
        rx_q.delete();
        link.dst_clear_i = 1'b1;
        #1;
        check("dclr_valid_drop", {31'd0, link.dst_valid_o}, 32'd0);
        tick();
        link.dst_clear_i = 1'b0;
        check("dclr_src_pend", {31'd0, link.src_clear_pending_o}, 32'd1);
        check("dclr_dst_pend", {31'd0, link.dst_clear_pending_o}, 32'd1);
        count_pending(n);
        check("dclr_pending_len", n, 32'd4);
        check("dclr_ready_back", {31'd0, link.src_ready_o}, 32'd1);
        link.dst_ready_i = 1'b1;
        repeat (6) tick();
        check("dclr_dropped", rx_q.size(), 32'd0);

        // Both clears together with a source offer in the same cycle.
        rx_q.delete();
        link.src_data_i  = 32'h0BADF00D;
        link.src_valid_i = 1'b1;
        link.src_clear_i = 1'b1;
        link.dst_clear_i = 1'b1;
        #1;
        check("both_ready_low", {31'd0, link.src_ready_o}, 32'd0);
        tick();
        link.src_clear_i = 1'b0;
        link.dst_clear_i = 1'b0;
        link.src_valid_i = 1'b0;
        count_pending(n);
        check("both_pending_len", n, 32'd4);
        repeat (6) tick();
        check("both_no_accept", rx_q.size(), 32'd0);
        check("both_valid_low", {31'd0, link.dst_valid_o}, 32'd0);

        // Reset mid-clear, then mid-transfer.
        link.dst_ready_i = 1'b0;
        send(32'h55AA55AA, a);
        tick();
        link.src_clear_i = 1'b1;
        tick();
        link.src_clear_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst_midclear");
        send(32'h66666666, a);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst_midxfer");
        repeat (6) tick();
        check("rst_no_valid", {31'd0, link.dst_valid_o}, 32'd0);

        // Randomized regression.
        seq_mode = 1'b1;
        last_seq = -1;
        seq = 0;
        holding = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!holding && $urandom_range(0, 99) < 60) begin
                link.src_valid_i = 1'b1;
                link.src_data_i  = {16'($urandom), 16'(seq)};
                seq++;
                holding = 1'b1;
            end
            link.dst_ready_i = ($urandom_range(0, 99) < 50);
            link.src_clear_i = ($urandom_range(0, 99) < 2);
            link.dst_clear_i = ($urandom_range(0, 99) < 2);
            #1;
            fire = link.src_valid_i && link.src_ready_o;
            tick();
            if (fire) begin
                holding = 1'b0;
                link.src_valid_i = 1'b0;
            end
        end
        link.src_clear_i = 1'b0;
        link.dst_clear_i = 1'b0;
        link.src_valid_i = 1'b0;
        link.dst_ready_i = 1'b1;
        repeat (20) tick();
        check("rand_balance", n_rx + n_drop, n_sent);
        check("rand_traffic", {31'd0, (n_rx > 20)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
